// File: rtl/step_countdown_if.sv
// Handshake bundle between the top-level control FSM (master) and the
// step countdown sequencer (slave).
interface step_countdown_if #(
    parameter int NBITS = 8
);
    logic             start;
    logic             abort;
    logic [NBITS-1:0] init_value;
    logic             step_ack;
    logic             step_req;
    logic             busy;
    logic             last_step;
    logic [NBITS-1:0] count;
    logic [NBITS-1:0] iter;
    logic             done;
    logic             aborted;

    modport master (
        output start, abort, init_value, step_ack,
        input  step_req, busy, last_step, count, iter, done, aborted
    );

    modport slave (
        input  start, abort, init_value, step_ack,
        output step_req, busy, last_step, count, iter, done, aborted
    );
endinterface

// File: rtl/step_countdown_ctrl.sv
// Issues one step request at a time to a stepped datapath, decrementing the
// remaining budget by STEP per acknowledged step until it is exhausted.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for start; count/iter hold last sequence's values
// S_RUN   | step_req high, waiting for step_ack
// S_GAP   | one cycle of step_req low between consecutive requests
// S_DONE  | one-cycle done pulse, budget exhausted
// S_ABORT | one-cycle aborted pulse, sequence cancelled
module step_countdown_ctrl #(
    parameter int NBITS = 8,
    parameter int STEP  = 2
) (
    input logic            clk,
    input logic            reset,
    step_countdown_if.slave bus
);
    localparam logic [NBITS-1:0] STEP_W = NBITS'(STEP);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_GAP,
        S_DONE,
        S_ABORT
    } state_t;

    state_t           r_state;
    logic [NBITS-1:0] r_count;
    logic [NBITS-1:0] r_iter;

    state_t           w_state_nxt;
    logic [NBITS-1:0] w_count_nxt;
    logic [NBITS-1:0] w_iter_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_iter  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_iter  <= w_iter_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_iter_nxt  = r_iter;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_count_nxt = bus.init_value;
                    w_iter_nxt  = '0;
                    w_state_nxt = (bus.init_value != '0) ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                // abort wins over a coincident ack; the ack is dropped
                if (bus.abort) begin
                    w_state_nxt = S_ABORT;
                end else if (bus.step_ack) begin
                    w_iter_nxt = r_iter + NBITS'(1);
                    if (r_count > STEP_W) begin
                        w_count_nxt = r_count - STEP_W;
                        w_state_nxt = S_GAP;
                    end else begin
                        w_count_nxt = '0;
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_GAP: begin
                w_state_nxt = bus.abort ? S_ABORT : S_RUN;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            S_ABORT: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign bus.step_req  = (r_state == S_RUN);
    assign bus.busy      = (r_state == S_RUN) || (r_state == S_GAP);
    assign bus.last_step = (r_state == S_RUN) && (r_count <= STEP_W);
    assign bus.done      = (r_state == S_DONE);
    assign bus.aborted   = (r_state == S_ABORT);
    assign bus.count     = r_count;
    assign bus.iter      = r_iter;
endmodule

// File: tb/tb_step_countdown_ctrl.sv
// Directed bench for step_countdown_ctrl: a cycle model checked every cycle
// plus literal expectations for each scenario.
module tb_step_countdown_ctrl;
    localparam int NBITS = 8;
    localparam int STEP  = 2;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    step_countdown_if #(.NBITS(NBITS)) bus();

    step_countdown_ctrl #(.NBITS(NBITS), .STEP(STEP)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Model: which phase of the sequence we are in, plus the budget arithmetic.
    bit m_req, m_gap, m_done, m_abt;
    int m_count, m_iter;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_req <= 0; m_gap <= 0; m_done <= 0; m_abt <= 0;
            m_count <= 0; m_iter <= 0;
        end else if (m_req) begin
            if (bus.abort) begin
                m_req <= 0; m_abt <= 1;
            end else if (bus.step_ack) begin
                m_iter <= (m_iter + 1) % (1 << NBITS);
                m_req  <= 0;
                if (m_count > STEP) begin
                    m_count <= m_count - STEP; m_gap <= 1;
                end else begin
                    m_count <= 0; m_done <= 1;
                end
            end
        end else if (m_gap) begin
            m_gap <= 0;
            if (bus.abort) m_abt <= 1;
            else m_req <= 1;
        end else if (m_done || m_abt) begin
            m_done <= 0; m_abt <= 0;
        end else if (bus.start) begin
            m_count <= int'(bus.init_value);
            m_iter  <= 0;
            if (bus.init_value != 0) m_req <= 1;
            else m_done <= 1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("step_req",  int'(bus.step_req),  int'(m_req));
            chk("busy",      int'(bus.busy),      int'(m_req | m_gap));
            chk("last_step", int'(bus.last_step), int'(m_req && (m_count <= STEP)));
            chk("done",      int'(bus.done),      int'(m_done));
            chk("aborted",   int'(bus.aborted),   int'(m_abt));
            chk("count",     int'(bus.count),     m_count);
            chk("iter",      int'(bus.iter),      m_iter);
        end
    end

    int req_counts[$];
    int n_req, n_done, n_abt, done_cyc, last_idx, fin_count, fin_iter;

    // Start a sequence, ack each request after 'delay' cycles, optionally
    // abort alongside the abort_ack-th ack; noise drives start while active.
    task automatic run_seq(input int init, input int delay, input int abort_ack, input bit noise);
        bit prev = 0;
        bit finished = 0;
        int req_cyc = 0;
        int acks = 0;
        req_counts.delete();
        n_req = 0; n_done = 0; n_abt = 0; done_cyc = -1; last_idx = 0;
        bus.init_value = NBITS'(init);
        bus.start = 1'b1;
        @(posedge clk); #2;
        bus.start = 1'b0;
        for (int cyc = 0; cyc < 200 && !finished; cyc++) begin
            if (bus.step_req && !prev) begin
                n_req++;
                req_counts.push_back(int'(bus.count));
            end
            if (bus.last_step && last_idx == 0) last_idx = n_req;
            prev = bus.step_req;
            if (bus.done) begin
                n_done++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (bus.aborted) n_abt++;
            fin_count = int'(bus.count);
            fin_iter  = int'(bus.iter);
            bus.step_ack = 1'b0;
            bus.abort    = 1'b0;
            bus.start    = noise && (bus.busy || bus.done);
            if (noise) bus.init_value = 8'hAA;
            if (bus.done || bus.aborted) begin
                finished = 1;
            end else if (bus.step_req) begin
                if (req_cyc == delay) begin
                    bus.step_ack = 1'b1;
                    acks++;
                    req_cyc = 0;
                    if (acks == abort_ack) bus.abort = 1'b1;
                end else begin
                    req_cyc++;
                end
            end else begin
                req_cyc = 0;
            end
            @(posedge clk); #2;
        end
        if (!finished) chk("seq_timeout", 0, 1);
        bus.start = 1'b0; bus.step_ack = 1'b0; bus.abort = 1'b0;
    endtask

    initial begin
        bus.start = 1'b0; bus.abort = 1'b0; bus.step_ack = 1'b0; bus.init_value = '0;
        #3 reset = 1'b0;
        chk_en = 1'b1;
        #1;
        chk("rst_count", int'(bus.count), 0);
        chk("rst_iter", int'(bus.iter), 0);
        chk("rst_outs", int'({bus.step_req, bus.busy, bus.last_step, bus.done, bus.aborted}), 0);
        @(posedge clk); @(posedge clk); #2;
        reset = 1'b1;
        // abort while idle is ignored
        bus.abort = 1'b1;
        @(posedge clk); #2;
        bus.abort = 1'b0;

        // budget 8: requests see 8,6,4,2; done 7 edges after the accepting edge
        run_seq(8, 0, 0, 0);
        chk("b8_nreq", n_req, 4);
        chk("b8_cnt0", req_counts.size() > 0 ? req_counts[0] : -1, 8);
        chk("b8_cnt3", req_counts.size() > 3 ? req_counts[3] : -1, 2);
        chk("b8_last_idx", last_idx, 4);
        chk("b8_done_cyc", done_cyc, 7);
        chk("b8_ndone", n_done, 1);
        chk("b8_fin", fin_count * 256 + fin_iter, 0 * 256 + 4);

        // budget 7: final step saturates at zero
        run_seq(7, 0, 0, 0);
        chk("b7_cnt3", req_counts.size() > 3 ? req_counts[3] : -1, 1);
        chk("b7_last_idx", last_idx, 4);
        chk("b7_fin_count", fin_count, 0);
        chk("b7_fin_iter", fin_iter, 4);
        chk("b7_ndone", n_done, 1);

        // budget 0: straight to done, no request
        run_seq(0, 0, 0, 0);
        chk("b0_nreq", n_req, 0);
        chk("b0_done_cyc", done_cyc, 0);
        chk("b0_iter", fin_iter, 0);

        // budget 10, 3-cycle ack delay, abort with 2nd ack
        run_seq(10, 3, 2, 0);
        chk("ab_count", fin_count, 8);
        chk("ab_iter", fin_iter, 1);
        chk("ab_nabt", n_abt, 1);
        chk("ab_ndone", n_done, 0);
        chk("ab_nreq", n_req, 2);

        // start held during RUN/GAP/DONE is ignored; then a fresh start of 4
        run_seq(6, 1, 0, 1);
        chk("ns_nreq", n_req, 3);
        chk("ns_fin_count", fin_count, 0);
        chk("ns_fin_iter", fin_iter, 3);
        run_seq(4, 0, 0, 0);
        chk("f4_nreq", n_req, 2);
        chk("f4_ndone", n_done, 1);
        chk("f4_done_cyc", done_cyc, 3);

        // async reset during GAP
        bus.init_value = 8'd6;
        bus.start = 1'b1;
        @(posedge clk); #2;
        bus.start = 1'b0;
        bus.step_ack = 1'b1;
        @(posedge clk); #2;
        bus.step_ack = 1'b0;
        chk("gap_reached", int'(bus.busy && !bus.step_req), 1);
        #1 reset = 1'b0;
        #1;
        chk("rg_outs", int'({bus.step_req, bus.busy, bus.last_step, bus.done, bus.aborted}), 0);
        chk("rg_count", int'(bus.count), 0);
        chk("rg_iter", int'(bus.iter), 0);
        @(posedge clk); #2;
        reset = 1'b1;
        run_seq(2, 0, 0, 0);
        chk("r2_nreq", n_req, 1);
        chk("r2_ndone", n_done, 1);
        chk("r2_nabt", n_abt, 0);
        chk("r2_iter", fin_iter, 1);

        @(posedge clk); #2;
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
